mvau_weight_stream: RTL and testbench

Weight streamer sitting directly upstream of a per-PE weight memory instance. It sweeps that memory's read address from 0 to WMEM_DEPTH-1 and wraps to 0. It absorbs the memory's fixed one-cycle registered read latency and presents the weight words on a ready/valid stream towards the PE's SIMD multiplier array. A small skid FIFO ensures downstream backpressure never loses a word, and gives one word per cycle when unstalled.

---
 rtl/mvau_weight_stream_if.sv | 12 +
 rtl/mvau_weight_stream.sv | 105 ++++++++++
 tb/tb_mvau_weight_stream.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mvau_weight_stream_if.sv
// Ready/valid weight stream from the streamer to a PE's SIMD multiplier array.
interface mvau_weight_stream_if #(
    parameter int unsigned DW = 2
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/mvau_weight_stream.sv
// Sweeps a weight memory's read address cyclically and streams the words out
// through a 2-entry skid FIFO that absorbs the one-cycle memory read latency.
module mvau_weight_stream #(
    parameter int unsigned SIMD         = 2,
    parameter int unsigned TW           = 1,
    parameter int unsigned WMEM_DEPTH   = 4,
    parameter int unsigned WMEM_ADDR_BW = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    en,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]      wmem_out,
    mvau_weight_stream_if.master    out_wgt
);
    localparam int unsigned DW = SIMD * TW;
    localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    logic          inflight;
    logic          tag_last;
    logic [DW-1:0] head_data;
    logic          head_last;
    logic          head_vld;
    logic [DW-1:0] skid_data;
    logic          skid_last;
    logic          skid_vld;
    logic          pop;
    logic          push;
    logic          issue;
    logic [1:0]    cnt;

    assign pop  = head_vld & out_wgt.tready;
    assign push = inflight;
    assign cnt  = 2'(head_vld) + 2'(skid_vld);
    // Only read when the word can be guaranteed a FIFO slot on capture.
    assign issue = en & ((3'(cnt) + 3'(inflight)) < (3'd2 + 3'(pop)));

    assign out_wgt.tdata  = head_data;
    assign out_wgt.tlast  = head_last;
    assign out_wgt.tvalid = head_vld;

    // Address sweep and 1-deep tag tracking the read in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wmem_addr <= '0;
            inflight  <= 1'b0;
            tag_last  <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag_last  <= (wmem_addr == LAST_ADDR);
                wmem_addr <= (wmem_addr == LAST_ADDR) ? '0
                                                      : wmem_addr + WMEM_ADDR_BW'(1);
            end
        end
    end

    // FWFT FIFO: head register drives the stream, skid register takes the overflow.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            head_data <= '0;
            head_last <= 1'b0;
            head_vld  <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
            skid_vld  <= 1'b0;
        end else begin
            assert (!(push && !pop && skid_vld));
            case ({push, pop})
                2'b11: begin
                    if (skid_vld) begin
                        head_data <= skid_data;
                        head_last <= skid_last;
                        skid_data <= wmem_out;
                        skid_last <= tag_last;
                    end else begin
                        head_data <= wmem_out;
                        head_last <= tag_last;
                    end
                end
                2'b01: begin
                    if (skid_vld) begin
                        head_data <= skid_data;
                        head_last <= skid_last;
                        skid_vld  <= 1'b0;
                    end else begin
                        head_vld  <= 1'b0;
                    end
                end
                2'b10: begin
                    if (head_vld) begin
                        skid_data <= wmem_out;
                        skid_last <= tag_last;
                        skid_vld  <= 1'b1;
                    end else begin
                        head_data <= wmem_out;
                        head_last <= tag_last;
                        head_vld  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mvau_weight_stream.sv
// Randomized bench for mvau_weight_stream: a word-count model predicts order,
// occupancy and tvalid; a second instance covers the single-word memory case.
module tb_mvau_weight_stream;
    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic       en = 1'b0;
    logic [3:0] wmem_addr;
    logic [3:0] wmem_out = 4'h0;
    logic [3:0] wmem_addr1;
    logic [3:0] wmem_out1 = 4'h0;
    logic [3:0] mem [0:3];

    int total = 0;
    int bad = 0;

    mvau_weight_stream_if #(.DW(4)) wif ();
    mvau_weight_stream_if #(.DW(4)) wif1 ();

    mvau_weight_stream #(.SIMD(2), .TW(2), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4)) dut (
        .aclk(clk), .aresetn(aresetn), .en(en),
        .wmem_addr(wmem_addr), .wmem_out(wmem_out), .out_wgt(wif));

    mvau_weight_stream #(.SIMD(2), .TW(2), .WMEM_DEPTH(1), .WMEM_ADDR_BW(4)) dut1 (
        .aclk(clk), .aresetn(aresetn), .en(en),
        .wmem_addr(wmem_addr1), .wmem_out(wmem_out1), .out_wgt(wif1));

    always #5 clk = ~clk;

    // Registered-read memory models.
    always @(posedge clk) begin
        wmem_out  <= mem[wmem_addr[1:0]];
        wmem_out1 <= (wmem_addr1 == 4'd0) ? 4'h5 : 4'h0;
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: words issued and popped since reset, plus last-cycle samples.
    int         issued, popped, beats1;
    bit         pend;
    int         p_addr;
    bit         p_en, p_vld, p_rdy, p_last;
    logic [3:0] p_data;
    logic [4:0] beats [$];

    always @(negedge clk) begin
        int occ, idx;
        bit changed;
        if (!aresetn) begin
            check("rst_addr", int'(wmem_addr), 0);
            check("rst_tvalid", int'(wif.tvalid), 0);
            check("rst_tlast", int'(wif.tlast), 0);
            check("rst_tdata", int'(wif.tdata), 0);
            issued = 0; popped = 0; pend = 1'b0;
            p_addr = 0; p_en = 1'b0; p_vld = 1'b0; p_rdy = 1'b0;
            p_last = 1'b0; p_data = 4'h0;
            beats.delete();
        end else begin
            if (pend) popped++;
            changed = (int'(wmem_addr) != p_addr);
            if (changed) begin
                check("addr_step", int'(wmem_addr), (p_addr + 1) % 4);
                issued++;
            end
            if (!p_en) check("no_issue_en0", int'(wmem_addr), p_addr);
            // Words already captured into the FIFO and not yet popped.
            occ = issued - (changed ? 1 : 0) - popped;
            check("occupancy", int'(occ >= 0 && occ <= 2), 1);
            check("tvalid", int'(wif.tvalid), int'(occ != 0));
            if (p_vld && !p_rdy) begin
                check("stall_valid", int'(wif.tvalid), 1);
                check("stall_data", int'(wif.tdata), int'(p_data));
                check("stall_last", int'(wif.tlast), int'(p_last));
            end
            if (wif.tvalid) begin
                idx = popped % 4;
                check("tdata", int'(wif.tdata), int'(mem[idx]));
                check("tlast", int'(wif.tlast), int'(idx == 3));
            end
            pend = wif.tvalid & wif.tready;
            if (pend) beats.push_back({wif.tlast, wif.tdata});
            p_addr = int'(wmem_addr); p_en = en;
            p_vld = wif.tvalid; p_rdy = wif.tready;
            p_data = wif.tdata; p_last = wif.tlast;
        end
    end

    // Single-word memory: address pinned at 0, every beat is the same word with tlast.
    always @(negedge clk) begin
        if (aresetn) begin
            check("d1_addr", int'(wmem_addr1), 0);
            if (wif1.tvalid) begin
                check("d1_data", int'(wif1.tdata), 5);
                check("d1_last", int'(wif1.tlast), 1);
                if (wif1.tready) beats1++;
            end
        end
    end

    always @(posedge clk) begin
        #1 wif1.tready = 1'($urandom_range(0, 1));
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp_run [0:7];
        int base, n, budget;
        logic [3:0] frozen;
        mem[0] = 4'hA; mem[1] = 4'hB; mem[2] = 4'hC; mem[3] = 4'hD;
        exp_run[0] = 5'h0A; exp_run[1] = 5'h0B; exp_run[2] = 5'h0C; exp_run[3] = 5'h1D;
        exp_run[4] = 5'h0A; exp_run[5] = 5'h0B; exp_run[6] = 5'h0C; exp_run[7] = 5'h1D;
        beats1 = 0;
        wif.tready = 1'b0;

        // Reset with random inputs, then release and measure first-word latency.
        repeat (5) begin
            cycles(1);
            en = 1'($urandom_range(0, 1));
            wif.tready = 1'($urandom_range(0, 1));
        end
        cycles(1);
        aresetn = 1'b1; en = 1'b1; wif.tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lat_after_e1", int'(wif.tvalid), 0);
        @(negedge clk);
        check("lat_after_e2", int'(wif.tvalid), 1);

        // Free run: exact cyclic sequence at one word per cycle.
        cycles(12);
        check("run_count", int'(beats.size() >= 8), 1);
        if (beats.size() >= 8)
            for (int i = 0; i < 8; i++) check($sformatf("run_beat%0d", i), int'(beats[i]), int'(exp_run[i]));

        // Random backpressure.
        for (int i = 0; i < 1000; i++) begin
            cycles(1);
            wif.tready = 1'($urandom_range(0, 1));
        end

        // Hard stall from steady state, then drain with reads blocked.
        wif.tready = 1'b1;
        cycles(5);
        wif.tready = 1'b0;
        cycles(3);
        frozen = wmem_addr;
        cycles(7);
        check("stall_addr_frozen", int'(wmem_addr), int'(frozen));
        check("stall_tvalid", int'(wif.tvalid), 1);
        en = 1'b0; wif.tready = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!wif.tvalid) break;
            n++;
        end
        check("stall_buffered", n, 2);
        cycles(1);
        en = 1'b1;

        // Enable gating with tready held high.
        for (int i = 0; i < 60; i++) begin
            if (i % 3 == 0) en = ~en;
            cycles(1);
        end
        en = 1'b1;

        // Reset mid-stream with a read in flight.
        cycles(3);
        base = popped; budget = 0;
        while (popped < base + 6 && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        check("mid_wait_budget", int'(budget < 50), 1);
        #1 aresetn = 1'b0;
        #1;
        check("mid_rst_tvalid", int'(wif.tvalid), 0);
        check("mid_rst_addr", int'(wmem_addr), 0);
        check("mid_rst_tdata", int'(wif.tdata), 0);
        cycles(3);
        aresetn = 1'b1;
        cycles(6);
        check("restart_count", int'(beats.size() >= 1), 1);
        if (beats.size() >= 1) check("restart_first", int'(beats[0]), int'(exp_run[0]));

        check("d1_beats_seen", int'(beats1 > 0), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
